// File: rtl/mem_port_arbiter.sv
// Arbitrates a single fixed-latency memory port between instruction fetch (read-only)
// and the data stage (read/write); one access in flight, data side preferred.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_87,
    input  logic              rst_87,
    input  logic              if_req_87,
    input  logic [ADDR_W-1:0] if_addr_87,
    output logic [DATA_W-1:0] if_rdata_87,
    output logic              if_done_87,
    output logic              if_stall_87,
    input  logic              dm_req_87,
    input  logic              dm_we_87,
    input  logic [ADDR_W-1:0] dm_addr_87,
    input  logic [DATA_W-1:0] dm_wdata_87,
    output logic [DATA_W-1:0] dm_rdata_87,
    output logic              dm_done_87,
    output logic              dm_stall_87,
    output logic              mem_en_87,
    output logic              mem_we_87,
    output logic [ADDR_W-1:0] mem_addr_87,
    output logic [DATA_W-1:0] mem_wdata_87,
    input  logic [DATA_W-1:0] mem_rdata_87,
    output logic              busy_87
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam int SC_W  = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] LAT_C    = CNT_W'(MEM_LAT);
    localparam logic [SC_W-1:0]  STARVE_C = SC_W'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state, state_nxt;
    logic              owner_if;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [CNT_W-1:0]  cnt;
    logic [SC_W-1:0]   starve_cnt;
    logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
    logic              any_req, grant_if;

    assign any_req  = if_req_87 || dm_req_87;
    // Fetch wins only when data is idle or fetch has waited out STARVE_MAX data grants.
    assign grant_if = if_req_87 && (!dm_req_87 || starve_cnt == STARVE_C);

    always_ff @(posedge clk_87) begin
        if (rst_87) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = lat_we ? DONE : WAIT;
            WAIT:    if (cnt == LAT_C) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_en_87  = 1'b0;
        mem_we_87  = 1'b0;
        if_done_87 = 1'b0;
        dm_done_87 = 1'b0;
        busy_87    = (state != IDLE);
        case (state)
            ISSUE: begin
                mem_en_87 = 1'b1;
                mem_we_87 = lat_we;
            end
            DONE: begin
                if_done_87 = owner_if;
                dm_done_87 = !owner_if;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_87) begin
        if (rst_87) begin
            owner_if   <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            cnt        <= '0;
            starve_cnt <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    owner_if <= grant_if;
                    lat_addr <= grant_if ? if_addr_87 : dm_addr_87;
                    lat_we   <= !grant_if && dm_we_87;
                    if (!grant_if) lat_wdata <= dm_wdata_87;
                    if (grant_if)
                        starve_cnt <= '0;
                    else if (if_req_87 && starve_cnt != STARVE_C)
                        starve_cnt <= starve_cnt + SC_W'(1);
                end
                ISSUE: cnt <= CNT_W'(1);
                WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAT_C) begin
                        if (owner_if) if_rdata_q <= mem_rdata_87;
                        else          dm_rdata_q <= mem_rdata_87;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr_87  = lat_addr;
    assign mem_wdata_87 = lat_wdata;
    assign if_rdata_87  = if_rdata_q;
    assign dm_rdata_87  = dm_rdata_q;
    // Stall is forced low while reset is asserted so every output reads zero in reset.
    assign if_stall_87  = if_req_87 && !if_done_87 && !rst_87;
    assign dm_stall_87  = dm_req_87 && !dm_done_87 && !rst_87;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected accesses and read data,
// a negedge monitor pops and compares on every mem_en / done pulse.
module tb_mem_port_arbiter;
    localparam int MEM_LAT = 2;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } mem_t;

    logic        clk_87 = 1'b0, rst_87 = 1'b1;
    logic        if_req_87, if_done_87, if_stall_87;
    logic [31:0] if_addr_87, if_rdata_87;
    logic        dm_req_87, dm_we_87, dm_done_87, dm_stall_87;
    logic [31:0] dm_addr_87, dm_wdata_87, dm_rdata_87;
    logic        mem_en_87, mem_we_87, busy_87;
    logic [31:0] mem_addr_87, mem_wdata_87, mem_rdata_87;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(4)) dut (
        .clk_87(clk_87), .rst_87(rst_87),
        .if_req_87(if_req_87), .if_addr_87(if_addr_87), .if_rdata_87(if_rdata_87),
        .if_done_87(if_done_87), .if_stall_87(if_stall_87),
        .dm_req_87(dm_req_87), .dm_we_87(dm_we_87), .dm_addr_87(dm_addr_87),
        .dm_wdata_87(dm_wdata_87), .dm_rdata_87(dm_rdata_87), .dm_done_87(dm_done_87),
        .dm_stall_87(dm_stall_87), .mem_en_87(mem_en_87), .mem_we_87(mem_we_87),
        .mem_addr_87(mem_addr_87), .mem_wdata_87(mem_wdata_87),
        .mem_rdata_87(mem_rdata_87), .busy_87(busy_87)
    );

    always #5 clk_87 = ~clk_87;

    int tests = 0, fails = 0;
    int cyc = 0, last_en_cyc = -100;
    mem_t        exp_mem[$];
    logic [31:0] exp_if[$];
    logic [31:0] exp_dm[$];

    always @(posedge clk_87) cyc <= cyc + 1;

    // Memory model: fixed contents plus a write overlay, MEM_LAT-stage read pipe.
    logic [31:0] wr_data [256];
    logic        wr_vld  [256];
    logic [31:0] rpipe   [MEM_LAT];

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        case (a)
            32'h040: return 32'h2108_0001;
            32'h080: return 32'h1357_9BDF;
            32'h0C0: return 32'h0C0C_0C0C;
            32'h0C4: return 32'h0C4C_4C4C;
            32'h100: return 32'h1111_1111;
            32'h200: return 32'h0BAD_F00D;
            32'h204: return 32'h1234_5678;
            default: return (a[31:8] == 24'h3) ? (32'h3000_0000 + {26'b0, a[7:2]}) : 32'h0;
        endcase
    endfunction

    always @(posedge clk_87) begin
        if (cyc == 0) begin
            for (int i = 0; i < 256; i++) wr_vld[i] <= 1'b0;
        end else if (mem_en_87 && mem_we_87) begin
            wr_vld[mem_addr_87[9:2]]  <= 1'b1;
            wr_data[mem_addr_87[9:2]] <= mem_wdata_87;
        end
        rpipe[0] <= (mem_en_87 && !mem_we_87) ?
                    (wr_vld[mem_addr_87[9:2]] ? wr_data[mem_addr_87[9:2]] : mem_init(mem_addr_87))
                    : 32'hEEEE_EEEE;
        for (int i = 1; i < MEM_LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_rdata_87 = rpipe[MEM_LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexp(input string name);
        tests++;
        fails++;
        $display("FAIL %s: pulse with empty scoreboard (cycle %0d)", name, cyc);
    endtask

    // Monitor
    initial begin
        mem_t m;
        forever begin
            @(negedge clk_87);
            chk("we_without_en", {31'b0, mem_we_87 & ~mem_en_87}, 32'h0);
            if (mem_en_87) begin
                last_en_cyc = cyc;
                if (exp_mem.size() == 0) unexp("mem_en_unexpected");
                else begin
                    m = exp_mem.pop_front();
                    chk("mem_addr", mem_addr_87, m.addr);
                    chk("mem_we", {31'b0, mem_we_87}, {31'b0, m.we});
                    if (m.we) chk("mem_wdata", mem_wdata_87, m.wdata);
                end
            end
            if (if_done_87) begin
                if (exp_if.size() == 0) unexp("if_done_unexpected");
                else chk("if_rdata", if_rdata_87, exp_if.pop_front());
            end
            if (dm_done_87) begin
                if (exp_dm.size() == 0) unexp("dm_done_unexpected");
                else chk("dm_rdata", dm_rdata_87, exp_dm.pop_front());
            end
        end
    end

    task automatic push_mem(input logic [31:0] a, input logic we, input logic [31:0] d);
        mem_t m;
        m.addr = a; m.we = we; m.wdata = d;
        exp_mem.push_back(m);
    endtask

    // Returns the done cycle relative to the first negedge waited on, and stall-high cycles before it.
    task automatic wait_done(input bit dm, input int bound, output int lat, output int st);
        lat = -1;
        st  = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk_87);
            if (dm ? dm_done_87 : if_done_87) begin
                lat = i;
                break;
            end
            if (dm ? dm_stall_87 : if_stall_87) st++;
        end
    endtask

    task automatic step();
        @(posedge clk_87);
        #1;
    endtask

    initial begin
        int t0, lat, st, nd, nf;
        int dm_at_f[2];
        if_req_87 = 1'b1; if_addr_87 = 32'h040;
        dm_req_87 = 1'b1; dm_we_87 = 1'b0; dm_addr_87 = 32'h204; dm_wdata_87 = 32'h0;

        // Reset with both requests pending: data first, fetch afterwards
        push_mem(32'h204, 1'b0, 32'h0);
        push_mem(32'h040, 1'b0, 32'h0);
        exp_dm.push_back(32'h1234_5678);
        exp_if.push_back(32'h2108_0001);
        @(posedge clk_87);
        @(negedge clk_87);
        chk("rst_ctrl_outs", {25'b0, busy_87, mem_en_87, mem_we_87, if_done_87, dm_done_87,
                              if_stall_87, dm_stall_87}, 32'h0);
        chk("rst_if_rdata", if_rdata_87, 32'h0);
        chk("rst_dm_rdata", dm_rdata_87, 32'h0);
        chk("rst_mem_addr", mem_addr_87, 32'h0);
        step();
        rst_87 = 1'b0;
        t0 = cyc;
        @(negedge clk_87);
        chk("rst_release_no_en", {31'b0, mem_en_87}, 32'h0);
        wait_done(1'b1, 20, lat, st);
        chk("rst_dm_lat", lat, 32'd3);
        chk("rst_first_en", last_en_cyc - t0, 32'd1);
        dm_req_87 = 1'b0;
        wait_done(1'b0, 20, lat, st);
        chk("rst_if_lat", lat, 32'd4);
        if_req_87 = 1'b0;
        repeat (2) step();

        // Single fetch read
        if_addr_87 = 32'h040; if_req_87 = 1'b1; t0 = cyc;
        push_mem(32'h040, 1'b0, 32'h0);
        exp_if.push_back(32'h2108_0001);
        wait_done(1'b0, 20, lat, st);
        chk("fetch_lat", lat, 32'd4);
        chk("fetch_stall_cycles", st, 32'd4);
        chk("fetch_stall_at_done", {31'b0, if_stall_87}, 32'h0);
        chk("fetch_en_cycle", last_en_cyc - t0, 32'd1);
        if_req_87 = 1'b0;
        repeat (2) step();

        // Both request together
        dm_addr_87 = 32'h200; dm_req_87 = 1'b1; if_addr_87 = 32'h080; if_req_87 = 1'b1; t0 = cyc;
        push_mem(32'h200, 1'b0, 32'h0);
        push_mem(32'h080, 1'b0, 32'h0);
        exp_dm.push_back(32'h0BAD_F00D);
        exp_if.push_back(32'h1357_9BDF);
        wait_done(1'b1, 20, lat, st);
        chk("both_dm_lat", lat, 32'd4);
        chk("both_dm_en", last_en_cyc - t0, 32'd1);
        dm_req_87 = 1'b0;
        wait_done(1'b0, 20, lat, st);
        chk("both_if_lat", lat, 32'd4);
        chk("both_if_en", last_en_cyc - t0, 32'd6);
        if_req_87 = 1'b0;
        repeat (2) step();

        // Starvation: data streams 9 reads, fetch needs two reads
        for (int k = 0; k < 4; k++) push_mem(32'h300 + 4 * k, 1'b0, 32'h0);
        push_mem(32'h0C0, 1'b0, 32'h0);
        for (int k = 4; k < 8; k++) push_mem(32'h300 + 4 * k, 1'b0, 32'h0);
        push_mem(32'h0C4, 1'b0, 32'h0);
        push_mem(32'h320, 1'b0, 32'h0);
        for (int k = 0; k < 9; k++) exp_dm.push_back(32'h3000_0000 + k);
        exp_if.push_back(32'h0C0C_0C0C);
        exp_if.push_back(32'h0C4C_4C4C);
        dm_at_f[0] = -1; dm_at_f[1] = -1; nd = 0; nf = 0;
        dm_addr_87 = 32'h300; dm_req_87 = 1'b1; if_addr_87 = 32'h0C0; if_req_87 = 1'b1;
        for (int c = 0; c < 200 && (dm_req_87 || if_req_87); c++) begin
            @(negedge clk_87);
            if (dm_done_87) begin
                nd++;
                if (nd == 9) dm_req_87 = 1'b0;
                else dm_addr_87 = 32'h300 + 4 * nd;
            end
            if (if_done_87) begin
                if (nf < 2) dm_at_f[nf] = nd;
                nf++;
                if (nf == 2) if_req_87 = 1'b0;
                else if_addr_87 = 32'h0C4;
            end
        end
        chk("starve_dm_count", nd, 32'd9);
        chk("starve_if_count", nf, 32'd2);
        chk("starve_first_fetch", dm_at_f[0], 32'd4);
        chk("starve_second_fetch", dm_at_f[1], 32'd8);
        dm_req_87 = 1'b0; if_req_87 = 1'b0;
        repeat (2) step();

        // Write then read back
        dm_we_87 = 1'b1; dm_addr_87 = 32'h100; dm_wdata_87 = 32'hDEAD_BEEF; dm_req_87 = 1'b1;
        t0 = cyc;
        push_mem(32'h100, 1'b1, 32'hDEAD_BEEF);
        exp_dm.push_back(32'h3000_0008);
        wait_done(1'b1, 20, lat, st);
        chk("write_lat", lat, 32'd2);
        chk("write_en_cycle", last_en_cyc - t0, 32'd1);
        dm_req_87 = 1'b0; dm_we_87 = 1'b0;
        repeat (2) step();
        dm_req_87 = 1'b1;
        push_mem(32'h100, 1'b0, 32'h0);
        exp_dm.push_back(32'hDEAD_BEEF);
        wait_done(1'b1, 20, lat, st);
        chk("readback_lat", lat, 32'd4);
        dm_req_87 = 1'b0;
        repeat (2) step();

        // Reset during WAIT abandons the fetch read
        if_addr_87 = 32'h040; if_req_87 = 1'b1;
        push_mem(32'h040, 1'b0, 32'h0);
        step();
        step();
        rst_87 = 1'b1; if_req_87 = 1'b0;
        step();
        rst_87 = 1'b0;
        @(negedge clk_87);
        chk("midrst_busy", {31'b0, busy_87}, 32'h0);
        chk("midrst_if_rdata", if_rdata_87, 32'h0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_87);
            chk("midrst_quiet", {30'b0, if_done_87 | dm_done_87, mem_en_87}, 32'h0);
        end
        step();
        dm_addr_87 = 32'h204; dm_req_87 = 1'b1;
        push_mem(32'h204, 1'b0, 32'h0);
        exp_dm.push_back(32'h1234_5678);
        wait_done(1'b1, 20, lat, st);
        chk("postrst_dm_lat", lat, 32'd4);
        dm_req_87 = 1'b0;

        repeat (3) @(negedge clk_87);
        chk("scoreboard_drained", exp_mem.size() + exp_if.size() + exp_dm.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
